mod_mult_seq: RTL and testbench

- Sequential interleaved (shift-add) modular multiplier: out = (a * b) mod modulus, one multiplier bit per clock, MSB first.
- Sits directly under the fast modular exponentiator and provides its square and multiply steps.
- Replaces the unbounded combinational product with a fixed-latency, synthesizable datapath.
- Start/done handshake, so the exponentiator controller can sequence square and multiply steps.

---
 rtl/rsa_pkg.sv | 13 +
 rtl/mod_mult_seq_if.sv | 28 ++
 rtl/mod_mult_seq_add_reduce.sv | 42 ++++
 rtl/mod_mult_seq.sv | 126 ++++++++++++
 tb/tb_mod_mult_seq.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rsa_pkg.sv
// Shared constants for the RSA datapath: FSM encoding and default width.
// Imported by the exponentiator and the sequential modular multiplier.
package rsa_pkg;

    localparam int RSA_N = 55;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mm_state_e;

endpackage

// File: rtl/mod_mult_seq_if.sv
// Start/done handshake and operand bus of the sequential modular multiplier.
// The controller drives master; the multiplier is the slave.
interface mod_mult_seq_if
    import rsa_pkg::*;
#(
    parameter int N = RSA_N
);

    logic         st;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] modulus;
    logic [N-1:0] out;
    logic         done;
    logic         busy;
    logic         err;

    modport master (
        output st, a, b, modulus,
        input  out, done, busy, err
    );

    modport slave (
        input  st, a, b, modulus,
        output out, done, busy, err
    );

endinterface

// File: rtl/mod_mult_seq_add_reduce.sv
// One interleaved step: 2*acc (+ addend) reduced back below m.
// Inputs satisfy acc < m and addend < m, so the sum is < 3m.
module mod_add_reduce
    import rsa_pkg::*;
#(
    parameter int N = RSA_N
) (
    input  logic [N-1:0] acc_i,
    input  logic [N-1:0] addend_i,
    input  logic         add_en_i,
    input  logic [N-1:0] m_i,
    output logic [N-1:0] acc_o
);

    localparam int W = N + 2;

    logic [N-1:0] add_sel;
    logic [W-1:0] t;
    logic [W-1:0] m1;
    logic [W-1:0] m2;
    logic [W-1:0] r;
    logic [1:0]   unused_hi;

    always_comb begin
        add_sel = add_en_i ? addend_i : {N{1'b0}};
        t       = {1'b0, acc_i, 1'b0} + {2'b00, add_sel};
        m1      = {2'b00, m_i};
        m2      = {1'b0, m_i, 1'b0};
        if (t >= m2) begin
            r = t - m2;
        end else if (t >= m1) begin
            r = t - m1;
        end else begin
            r = t;
        end
    end

    // r < m after reduction, so the two top bits are always zero
    assign unused_hi = r[W-1:N];
    assign acc_o     = r[N-1:0];

endmodule

// File: rtl/mod_mult_seq.sv
// Sequential shift-add modular multiplier: out = a*b mod modulus,
// one multiplier bit per clock, MSB first, N+1 cycles start to done.
module mod_mult_seq
    import rsa_pkg::*;
#(
    parameter int N     = RSA_N,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           reset,
    mod_mult_seq_if.slave  bus
);

    mm_state_e      state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   m_q, m_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]   out_q, out_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;

    logic [N-1:0]   acc_nx;
    logic           range_bad;

    mod_add_reduce #(
        .N (N)
    ) u_step (
        .acc_i    (acc_q),
        .addend_i (a_q),
        .add_en_i (b_q[cnt_q]),
        .m_i      (m_q),
        .acc_o    (acc_nx)
    );

    assign range_bad = (bus.modulus == '0)
                    || (bus.a >= bus.modulus)
                    || (bus.b >= bus.modulus);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.st) begin
                    a_d = bus.a;
                    b_d = bus.b;
                    m_d = bus.modulus;
                    if (range_bad) begin
                        err_d   = 1'b1;
                        out_d   = '0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = FIN;
                    end else begin
                        err_d   = 1'b0;
                        acc_d   = '0;
                        cnt_d   = CNT_W'(N - 1);
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = acc_nx;
                if (cnt_q == '0) begin
                    out_d   = acc_nx;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_mod_mult_seq.sv
// Directed and random checks of mod_mult_seq: result, latency,
// handshake, range errors and reset abort.
module tb_mod_mult_seq;

    localparam int N = 55;
    localparam logic [N-1:0] MAXM = '1;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    mod_mult_seq_if #(.N(N)) bus ();

    mod_mult_seq #(
        .N     (N),
        .CNT_W (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts one operation from IDLE and returns after the cycle following done.
    task automatic run_op(
        input  logic [N-1:0] ta,
        input  logic [N-1:0] tb,
        input  logic [N-1:0] tm,
        input  bit           chk_busy,
        output int           lat,
        output logic [N-1:0] o,
        output logic         e,
        output bit           busy_ok,
        output bit           pulse_ok,
        output logic         e_after
    );
        bus.a       = ta;
        bus.b       = tb;
        bus.modulus = tm;
        bus.st      = 1'b1;
        step();
        bus.st      = 1'b0;
        bus.a       = '1;
        bus.b       = '1;
        bus.modulus = '1;
        lat     = 1;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (chk_busy && bus.busy !== 1'b1) busy_ok = 1'b0;
            step();
            lat++;
        end
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        o = bus.out;
        e = bus.err;
        step();
        pulse_ok = (bus.done === 1'b0);
        e_after  = bus.err;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.st      = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        bus.modulus = '0;
        repeat (3) step();
        vectors += 4;
        if (bus.out !== '0) begin
            miscompares++;
            $display("FAIL reset_out: got %0d want 0", bus.out);
        end
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done: got %b want 0", bus.done);
        end
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        if (bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: got %b want 0", bus.err);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int lat;
        logic [N-1:0] o;
        logic e, e2;
        bit bok, pok;
        run_op(N'(7), N'(9), N'(11), 1'b1, lat, o, e, bok, pok, e2);
        vectors += 5;
        if (lat !== 56) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d want 56", lat);
        end
        if (o !== N'(8)) begin
            miscompares++;
            $display("FAIL basic_out: got %0d want 8", o);
        end
        if (e !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_err: got %b want 0", e);
        end
        if (!bok) begin
            miscompares++;
            $display("FAIL basic_busy: got bad busy window want high cycles 1-55");
        end
        if (!pok) begin
            miscompares++;
            $display("FAIL basic_done_pulse: got done still high want 0");
        end
    endtask

    task automatic test_max();
        int lat;
        logic [N-1:0] o;
        logic e, e2;
        bit bok, pok;
        run_op(MAXM - 1'b1, MAXM - 1'b1, MAXM, 1'b1, lat, o, e, bok, pok, e2);
        vectors += 3;
        if (lat !== 56) begin
            miscompares++;
            $display("FAIL max_latency: got %0d want 56", lat);
        end
        if (o !== N'(1)) begin
            miscompares++;
            $display("FAIL max_out: got %0d want 1", o);
        end
        if (e !== 1'b0) begin
            miscompares++;
            $display("FAIL max_err: got %b want 0", e);
        end
        run_op(N'(0), N'(12345), N'(99991), 1'b1, lat, o, e, bok, pok, e2);
        vectors++;
        if (o !== N'(0)) begin
            miscompares++;
            $display("FAIL zero_a_out: got %0d want 0", o);
        end
        run_op(N'(0), N'(0), N'(1), 1'b1, lat, o, e, bok, pok, e2);
        vectors += 2;
        if (o !== N'(0)) begin
            miscompares++;
            $display("FAIL mod1_out: got %0d want 0", o);
        end
        if (e !== 1'b0) begin
            miscompares++;
            $display("FAIL mod1_err: got %b want 0", e);
        end
    endtask

    task automatic test_range();
        int lat;
        logic [N-1:0] o;
        logic e, e2;
        bit bok, pok;
        run_op(N'(13), N'(2), N'(11), 1'b0, lat, o, e, bok, pok, e2);
        vectors += 5;
        if (lat !== 1) begin
            miscompares++;
            $display("FAIL range_latency: got %0d want 1", lat);
        end
        if (e !== 1'b1) begin
            miscompares++;
            $display("FAIL range_err: got %b want 1", e);
        end
        if (o !== N'(0)) begin
            miscompares++;
            $display("FAIL range_out: got %0d want 0", o);
        end
        if (e2 !== 1'b1) begin
            miscompares++;
            $display("FAIL range_err_hold: got %b want 1", e2);
        end
        if (!bok) begin
            miscompares++;
            $display("FAIL range_busy: got busy high want 0");
        end
        run_op(N'(5), N'(3), N'(0), 1'b0, lat, o, e, bok, pok, e2);
        vectors += 2;
        if (e !== 1'b1) begin
            miscompares++;
            $display("FAIL mod0_err: got %b want 1", e);
        end
        if (lat !== 1) begin
            miscompares++;
            $display("FAIL mod0_latency: got %0d want 1", lat);
        end
        run_op(N'(3), N'(4), N'(5), 1'b1, lat, o, e, bok, pok, e2);
        vectors += 3;
        if (e !== 1'b0) begin
            miscompares++;
            $display("FAIL range_clear_err: got %b want 0", e);
        end
        if (o !== N'(2)) begin
            miscompares++;
            $display("FAIL range_clear_out: got %0d want 2", o);
        end
        if (lat !== 56) begin
            miscompares++;
            $display("FAIL range_clear_latency: got %0d want 56", lat);
        end
    endtask

    task automatic test_start_while_busy();
        int c, n, first;
        logic [N-1:0] o;
        bus.a       = N'(5);
        bus.b       = N'(6);
        bus.modulus = N'(7);
        bus.st      = 1'b1;
        step();
        bus.st = 1'b0;
        c = 1;
        n = 0;
        first = 0;
        o = '0;
        while (c < 120) begin
            if (bus.done === 1'b1) begin
                n++;
                if (n == 1) begin
                    first = c;
                    o = bus.out;
                end
            end
            bus.st = (c == 10);
            if (c == 10) begin
                bus.a       = N'(1);
                bus.b       = N'(1);
                bus.modulus = N'(3);
            end
            step();
            c++;
        end
        bus.st = 1'b0;
        vectors += 3;
        if (n !== 1) begin
            miscompares++;
            $display("FAIL busy_start_count: got %0d dones want 1", n);
        end
        if (first !== 56) begin
            miscompares++;
            $display("FAIL busy_start_latency: got %0d want 56", first);
        end
        if (o !== N'(2)) begin
            miscompares++;
            $display("FAIL busy_start_out: got %0d want 2", o);
        end
    endtask

    task automatic test_back_to_back();
        int t, n;
        int d[4];
        bit out_ok;
        d = '{default: 0};
        bus.a       = N'(7);
        bus.b       = N'(9);
        bus.modulus = N'(11);
        bus.st      = 1'b1;
        t = 0;
        n = 0;
        out_ok = 1'b1;
        repeat (180) begin
            step();
            t++;
            if (bus.done === 1'b1) begin
                if (n < 4) d[n] = t;
                n++;
                if (bus.out !== N'(8)) out_ok = 1'b0;
            end
        end
        bus.st = 1'b0;
        repeat (60) step();
        vectors += 5;
        if (n !== 3) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d want 3", n);
        end
        if (d[0] !== 56) begin
            miscompares++;
            $display("FAIL b2b_first: got %0d want 56", d[0]);
        end
        if (d[1] - d[0] !== 57) begin
            miscompares++;
            $display("FAIL b2b_period1: got %0d want 57", d[1] - d[0]);
        end
        if (d[2] - d[1] !== 57) begin
            miscompares++;
            $display("FAIL b2b_period2: got %0d want 57", d[2] - d[1]);
        end
        if (!out_ok) begin
            miscompares++;
            $display("FAIL b2b_out: got wrong result want 8");
        end
    endtask

    task automatic test_reset_mid();
        int c, n, lat;
        logic [N-1:0] o;
        logic e, e2;
        bit bok, pok;
        bus.a       = N'(5);
        bus.b       = N'(6);
        bus.modulus = N'(7);
        bus.st      = 1'b1;
        step();
        bus.st = 1'b0;
        c = 1;
        while (c < 30) begin
            step();
            c++;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors += 3;
        if (bus.out !== '0) begin
            miscompares++;
            $display("FAIL abort_out: got %0d want 0", bus.out);
        end
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_busy: got %b want 0", bus.busy);
        end
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_done: got %b want 0", bus.done);
        end
        n = 0;
        repeat (80) begin
            step();
            if (bus.done === 1'b1) n++;
        end
        vectors++;
        if (n !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d dones want 0", n);
        end
        run_op(N'(10), N'(10), N'(13), 1'b1, lat, o, e, bok, pok, e2);
        vectors += 2;
        if (o !== N'(9)) begin
            miscompares++;
            $display("FAIL abort_restart_out: got %0d want 9", o);
        end
        if (lat !== 56) begin
            miscompares++;
            $display("FAIL abort_restart_latency: got %0d want 56", lat);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [N-1:0] o, ra, rb, rm, expv;
        logic e, e2;
        bit bok, pok;
        logic [63:0] r64, tmp;
        logic [2*N-1:0] p, rem;
        for (int i = 0; i < 1000; i++) begin
            r64 = {$urandom(), $urandom()};
            rm  = r64[N-1:0] >> (i % 54);
            if (rm == '0) rm = N'(1);
            r64 = {$urandom(), $urandom()};
            tmp = r64 % {9'd0, rm};
            ra  = tmp[N-1:0];
            r64 = {$urandom(), $urandom()};
            tmp = r64 % {9'd0, rm};
            rb  = tmp[N-1:0];
            p    = {{N{1'b0}}, ra} * {{N{1'b0}}, rb};
            rem  = p % {{N{1'b0}}, rm};
            expv = rem[N-1:0];
            run_op(ra, rb, rm, 1'b1, lat, o, e, bok, pok, e2);
            vectors += 2;
            if (o !== expv) begin
                miscompares++;
                $display("FAIL rand_out[%0d]: got %0d want %0d", i, o, expv);
            end
            if (lat !== 56) begin
                miscompares++;
                $display("FAIL rand_latency[%0d]: got %0d want 56", i, lat);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_max();
        test_range();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
